// File: rtl/fp_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fp_mult_pipe
// Brief    : Parametrised floating-point multiplier, round-to-nearest-even,
//            flush-to-zero denormals, valid/ready handshake, tag sideband.
//            Operand register, then classify, multiply and round/pack stages.
// Revision : 1.0 - initial release
// ============================================================================
module fp_mult_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     i_valid,
  output logic                     i_ready,
  input  logic [EXP_W+MAN_W:0]     i_a,
  input  logic [EXP_W+MAN_W:0]     i_b,
  input  logic [TAG_W-1:0]         i_tag,
  output logic                     o_valid,
  input  logic                     o_ready,
  output logic [EXP_W+MAN_W:0]     o_result,
  output logic [TAG_W-1:0]         o_tag,
  output logic [3:0]               o_flags
);

  localparam int                      c_w     = 1 + EXP_W + MAN_W;
  localparam int                      c_pw    = 2 * MAN_W + 2;
  localparam logic [EXP_W-1:0]        c_emax  = '1;
  localparam logic signed [EXP_W+1:0] c_bias  = (EXP_W+2)'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EXP_W+1:0] c_emaxs = (EXP_W+2)'((1 << EXP_W) - 1);
  localparam logic signed [EXP_W+1:0] c_zero  = '0;

  // Whole pipe advances together; a stalled output freezes every stage.
  logic w_en;
  assign w_en    = !o_valid || o_ready;
  assign i_ready = w_en;

  // Operand register stage
  logic               r0_valid;
  logic [c_w-1:0]     r0_a, r0_b;
  logic [TAG_W-1:0]   r0_tag;

  // Capture the accepted operand pair so classification starts from a flop.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r0_valid <= 1'b0;
      r0_a     <= '0;
      r0_b     <= '0;
      r0_tag   <= '0;
    end else if (w_en) begin
      r0_valid <= i_valid;
      r0_a     <= i_a;
      r0_b     <= i_b;
      r0_tag   <= i_tag;
    end
  end

  // Stage 1: unpack and classify
  logic [EXP_W-1:0]        w_ea, w_eb;
  logic [MAN_W-1:0]        w_ma, w_mb;
  logic                    w_a_zero, w_a_inf, w_a_nan;
  logic                    w_b_zero, w_b_inf, w_b_nan;
  logic signed [EXP_W+1:0] w_esum;

  assign w_ea     = r0_a[c_w-2:MAN_W];
  assign w_eb     = r0_b[c_w-2:MAN_W];
  assign w_ma     = r0_a[MAN_W-1:0];
  assign w_mb     = r0_b[MAN_W-1:0];
  // Exponent zero covers denormals: they are treated as zero.
  assign w_a_zero = (w_ea == '0);
  assign w_b_zero = (w_eb == '0);
  assign w_a_inf  = (w_ea == c_emax) && (w_ma == '0);
  assign w_b_inf  = (w_eb == c_emax) && (w_mb == '0);
  assign w_a_nan  = (w_ea == c_emax) && (w_ma != '0);
  assign w_b_nan  = (w_eb == c_emax) && (w_mb != '0);
  assign w_esum   = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - c_bias;

  logic                    r1_valid, r1_sign, r1_nan, r1_inf, r1_zero;
  logic signed [EXP_W+1:0] r1_exp;
  logic [MAN_W:0]          r1_sa, r1_sb;
  logic [TAG_W-1:0]        r1_tag;

  // Register class flags, signed exponent sum and significands with hidden 1.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r1_valid <= 1'b0;
      r1_sign  <= 1'b0;
      r1_nan   <= 1'b0;
      r1_inf   <= 1'b0;
      r1_zero  <= 1'b0;
      r1_exp   <= '0;
      r1_sa    <= '0;
      r1_sb    <= '0;
      r1_tag   <= '0;
    end else if (w_en) begin
      r1_valid <= r0_valid;
      r1_sign  <= r0_a[c_w-1] ^ r0_b[c_w-1];
      r1_nan   <= w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero);
      r1_inf   <= w_a_inf || w_b_inf;
      r1_zero  <= w_a_zero || w_b_zero;
      r1_exp   <= w_esum;
      r1_sa    <= {1'b1, w_ma};
      r1_sb    <= {1'b1, w_mb};
      r1_tag   <= r0_tag;
    end
  end

  // Stage 2: significand product
  logic                    r2_valid, r2_sign, r2_nan, r2_inf, r2_zero;
  logic signed [EXP_W+1:0] r2_exp;
  logic [c_pw-1:0]         r2_prod;
  logic [TAG_W-1:0]        r2_tag;

  // Multiply significands; class, sign, exponent and tag ride alongside.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r2_valid <= 1'b0;
      r2_sign  <= 1'b0;
      r2_nan   <= 1'b0;
      r2_inf   <= 1'b0;
      r2_zero  <= 1'b0;
      r2_exp   <= '0;
      r2_prod  <= '0;
      r2_tag   <= '0;
    end else if (w_en) begin
      r2_valid <= r1_valid;
      r2_sign  <= r1_sign;
      r2_nan   <= r1_nan;
      r2_inf   <= r1_inf;
      r2_zero  <= r1_zero;
      r2_exp   <= r1_exp;
      r2_prod  <= r1_sa * r1_sb;
      r2_tag   <= r1_tag;
    end
  end

  // Stage 3: normalise, round to nearest even, pack
  logic                    w_msb, w_guard, w_sticky, w_round_up, w_inexact;
  logic [c_pw-2:0]         w_norm;
  logic [MAN_W-1:0]        w_frac;
  logic [MAN_W:0]          w_frac_sum;
  logic signed [EXP_W+1:0] w_exp_n, w_exp_r;
  logic [c_w-1:0]          w_result;
  logic [3:0]              w_flags;

  // Product is in [1,4): a set MSB means the value is already one bit too high,
  // so the fraction window starts one bit lower and the exponent bumps.
  assign w_msb      = r2_prod[c_pw-1];
  assign w_norm     = w_msb ? r2_prod[c_pw-2:0] : {r2_prod[c_pw-3:0], 1'b0};
  assign w_frac     = w_norm[c_pw-2 -: MAN_W];
  assign w_guard    = w_norm[MAN_W];
  assign w_sticky   = |w_norm[MAN_W-1:0];
  assign w_round_up = w_guard && (w_sticky || w_frac[0]);
  assign w_frac_sum = {1'b0, w_frac} + {{MAN_W{1'b0}}, w_round_up};
  assign w_exp_n    = r2_exp + $signed({{(EXP_W+1){1'b0}}, w_msb});
  // A rounding carry leaves the fraction at zero and raises the exponent.
  assign w_exp_r    = w_exp_n + $signed({{(EXP_W+1){1'b0}}, w_frac_sum[MAN_W]});
  assign w_inexact  = w_guard || w_sticky;

  // Select the packed result by special-case priority.
  always_comb begin
    w_result = {r2_sign, w_exp_r[EXP_W-1:0], w_frac_sum[MAN_W-1:0]};
    w_flags  = {3'b000, w_inexact};
    if (r2_nan) begin
      w_result = {1'b0, c_emax, 1'b1, {(MAN_W-1){1'b0}}};
      w_flags  = 4'b1000;
    end else if (r2_inf) begin
      w_result = {r2_sign, c_emax, {MAN_W{1'b0}}};
      w_flags  = 4'b0000;
    end else if (r2_zero) begin
      w_result = {r2_sign, {(EXP_W+MAN_W){1'b0}}};
      w_flags  = 4'b0000;
    end else if (w_exp_r >= c_emaxs) begin
      w_result = {r2_sign, c_emax, {MAN_W{1'b0}}};
      w_flags  = 4'b0101;
    end else if (w_exp_r <= c_zero) begin
      w_result = {r2_sign, {(EXP_W+MAN_W){1'b0}}};
      w_flags  = 4'b0011;
    end
  end

  // Registered outputs; held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      o_valid  <= 1'b0;
      o_result <= '0;
      o_tag    <= '0;
      o_flags  <= '0;
    end else if (w_en) begin
      o_valid  <= r2_valid;
      o_result <= w_result;
      o_tag    <= r2_tag;
      o_flags  <= w_flags;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_mult_pipe
// Brief    : Scoreboard bench for fp_mult_pipe: directed vectors on an fp32
//            instance and a half-precision instance, backpressure and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_mult_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        i_valid, i_ready, o_valid, o_ready;
  logic [31:0] i_a, i_b, o_result;
  logic [3:0]  i_tag, o_tag, o_flags;

  logic        h_i_valid, h_i_ready, h_o_valid, h_o_ready;
  logic [15:0] h_i_a, h_i_b, h_o_result;
  logic [3:0]  h_i_tag, h_o_tag, h_o_flags;

  fp_mult_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
    .clk(clk), .rstn(rstn), .i_valid(i_valid), .i_ready(i_ready),
    .i_a(i_a), .i_b(i_b), .i_tag(i_tag), .o_valid(o_valid),
    .o_ready(o_ready), .o_result(o_result), .o_tag(o_tag), .o_flags(o_flags)
  );

  fp_mult_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) dut_h (
    .clk(clk), .rstn(rstn), .i_valid(h_i_valid), .i_ready(h_i_ready),
    .i_a(h_i_a), .i_b(h_i_b), .i_tag(h_i_tag), .o_valid(h_o_valid),
    .o_ready(h_o_ready), .o_result(h_o_result), .o_tag(h_o_tag), .o_flags(h_o_flags)
  );

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  tag;
    logic [3:0]  flags;
  } exp_t;

  exp_t sb_q[$];
  exp_t hq[$];
  exp_t m_e, h_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, got, want);
  endtask

  // Monitor for the fp32 instance: sampled just after the falling edge.
  logic        stall_prev = 1'b0;
  logic [39:0] stall_snap;
  always begin
    @(negedge clk);
    #1;
    if (rstn === 1'b1 && o_valid === 1'b1 && o_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_result", 64'(o_valid), 64'(0));
      end else begin
        m_e = sb_q.pop_front();
        chk("result", 64'(o_result), 64'(m_e.res));
        chk("tag", 64'(o_tag), 64'(m_e.tag));
        chk("flags", 64'(o_flags), 64'(m_e.flags));
      end
      stall_prev = 1'b0;
    end else if (rstn === 1'b1 && o_valid === 1'b1 && o_ready === 1'b0) begin
      chk("i_ready_stalled", 64'(i_ready), 64'(0));
      if (stall_prev) chk("stall_stable", 64'({o_result, o_tag, o_flags}), 64'(stall_snap));
      stall_snap = {o_result, o_tag, o_flags};
      stall_prev = 1'b1;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Monitor for the half-precision instance (never stalled).
  always begin
    @(negedge clk);
    #1;
    if (rstn === 1'b1 && h_o_valid === 1'b1) begin
      if (hq.size() == 0) begin
        chk("h_unexpected_result", 64'(h_o_valid), 64'(0));
      end else begin
        h_e = hq.pop_front();
        chk("h_result", 64'(h_o_result), 64'(h_e.res));
        chk("h_tag", 64'(h_o_tag), 64'(h_e.tag));
        chk("h_flags", 64'(h_o_flags), 64'(h_e.flags));
      end
    end
  end

  // Present one operation at a falling edge and hold it until accepted.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                      input logic [31:0] res, input logic [3:0] fl);
    logic acc;
    int   tries;
    exp_t e;
    acc   = 1'b0;
    tries = 0;
    e.res = res; e.tag = tag; e.flags = fl;
    i_valid = 1'b1; i_a = a; i_b = b; i_tag = tag;
    while (!acc && tries < 20) begin
      #1;
      acc = i_ready;
      @(posedge clk);
      if (acc) sb_q.push_back(e);
      @(negedge clk);
      tries++;
    end
    i_valid = 1'b0;
    if (!acc) chk("send_timeout", 64'(i_ready), 64'(1));
  endtask

  task automatic send_h(input logic [15:0] a, input logic [15:0] b, input logic [3:0] tag,
                        input logic [15:0] res, input logic [3:0] fl);
    exp_t e;
    e.res = {16'h0, res}; e.tag = tag; e.flags = fl;
    h_i_valid = 1'b1; h_i_a = a; h_i_b = b; h_i_tag = tag;
    #1;
    if (h_i_ready) hq.push_back(e);
    else chk("h_i_ready", 64'(h_i_ready), 64'(1));
    @(posedge clk);
    @(negedge clk);
    h_i_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb_q.size() != 0 || hq.size() != 0) && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
  endtask

  int w;

  initial begin
    rstn = 1'b0; i_valid = 1'b0; i_a = '0; i_b = '0; i_tag = '0; o_ready = 1'b1;
    h_i_valid = 1'b0; h_i_a = '0; h_i_b = '0; h_i_tag = '0; h_o_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_o_valid", 64'(o_valid), 64'(0));
    chk("reset_o_result", 64'(o_result), 64'(0));
    chk("reset_o_tag", 64'(o_tag), 64'(0));
    chk("reset_o_flags", 64'(o_flags), 64'(0));
    rstn = 1'b1;
    #1;
    chk("reset_i_ready", 64'(i_ready), 64'(1));
    @(negedge clk);

    // Latency: accepted at edge N, visible after edge N+3 and not before.
    send(32'h3FC00000, 32'h40000000, 4'h5, 32'h40400000, 4'b0000);
    repeat (2) @(negedge clk);
    chk("latency_early", 64'(o_valid), 64'(0));
    @(negedge clk);
    chk("latency_n3", 64'(o_valid), 64'(1));
    drain();

    // Rounding, specials and range, issued back to back.
    send(32'h3F800001, 32'h3F800001, 4'h1, 32'h3F800002, 4'b0001);
    send(32'h3F800001, 32'h3FC00000, 4'h2, 32'h3FC00002, 4'b0001);
    send(32'h7F800000, 32'h00000000, 4'h3, 32'h7FC00000, 4'b1000);
    send(32'hFF800000, 32'h40000000, 4'h4, 32'hFF800000, 4'b0000);
    send(32'h80000000, 32'h3F800000, 4'h6, 32'h80000000, 4'b0000);
    send(32'h00000001, 32'h3F800000, 4'h7, 32'h00000000, 4'b0000);
    send(32'h7F000000, 32'h40000000, 4'h8, 32'h7F800000, 4'b0101);
    send(32'h00800000, 32'hBF000000, 4'h9, 32'h80000000, 4'b0011);
    send(32'h7FC00000, 32'hFF800000, 4'hB, 32'h7FC00000, 4'b1000);
    drain();

    // Backpressure: five ops streamed, consumer stalls 4 cycles after first result.
    fork
      begin
        send(32'h3F800000, 32'h40000000, 4'h1, 32'h40000000, 4'b0000);
        send(32'h40000000, 32'h40000000, 4'h2, 32'h40800000, 4'b0000);
        send(32'h40400000, 32'h40000000, 4'h3, 32'h40C00000, 4'b0000);
        send(32'h40800000, 32'h3F000000, 4'h4, 32'h40000000, 4'b0000);
        send(32'hC0000000, 32'h40400000, 4'h5, 32'hC0C00000, 4'b0000);
      end
      begin
        w = 0;
        while (o_valid !== 1'b1 && w < 20) begin
          @(negedge clk);
          w++;
        end
        if (o_valid !== 1'b1) chk("stall_wait", 64'(o_valid), 64'(1));
        @(negedge clk);
        o_ready = 1'b0;
        repeat (4) @(negedge clk);
        o_ready = 1'b1;
      end
    join
    drain();

    // Reset while three operations are in flight: all of them are discarded.
    send(32'h40000000, 32'h40000000, 4'hC, 32'h40800000, 4'b0000);
    send(32'h40400000, 32'h40400000, 4'hD, 32'h41100000, 4'b0000);
    send(32'h3F800000, 32'h3F800000, 4'hE, 32'h3F800000, 4'b0000);
    rstn = 1'b0;
    sb_q.delete();
    @(negedge clk);
    rstn = 1'b1;
    chk("midreset_o_valid", 64'(o_valid), 64'(0));
    chk("midreset_o_tag", 64'(o_tag), 64'(0));
    repeat (8) @(negedge clk);
    send(32'h40000000, 32'h40400000, 4'hA, 32'h40C00000, 4'b0000);
    drain();

    // Half precision instance.
    send_h(16'h3E00, 16'h4000, 4'h1, 16'h4200, 4'b0000);
    send_h(16'h7800, 16'h7800, 4'h2, 16'h7C00, 4'b0101);
    drain();

    chk("scoreboard_empty", 64'(sb_q.size()), 64'(0));
    chk("h_scoreboard_empty", 64'(hq.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
